// File: rtl/seq_step_ctrl_if.sv
// Purpose  : bundles the step sequencer's control, pattern and detector signals.
// Latency  : n/a (signal bundle only).
// Backpress: none; the controller consumes every input each cycle.
// Ports    : master = the side that drives mode/button/pattern/start/abort/det_in,
//            slave  = seq_step_ctrl, which drives step/bit_out/busy/done/idx/match_cnt.
interface seq_step_ctrl_if #(
  parameter int PAT_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8
);
  logic               mode;
  logic               btn_next;
  logic               sw_in;
  logic [PAT_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               start;
  logic               abort;
  logic               det_in;
  logic               step;
  logic               bit_out;
  logic               busy;
  logic               done;
  logic [LEN_W-1:0]   idx;
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output mode, btn_next, sw_in, pattern, len, start, abort, det_in,
    input  step, bit_out, busy, done, idx, match_cnt
  );

  modport slave (
    input  mode, btn_next, sw_in, pattern, len, start, abort, det_in,
    output step, bit_out, busy, done, idx, match_cnt
  );
endinterface

// File: rtl/seq_step_ctrl.sv
// Purpose  : step/bit sequencer for a sequence detector; manual (debounced button + switch)
//            or auto (timed replay of a pattern LSB-first), counting detector hits per step.
// Latency  : auto steps land STEP_DIV cycles apart starting STEP_DIV cycles after start;
//            manual step fires the cycle the debounced button level rises.
// Backpress: none; start/button events outside IDLE are dropped, abort ends a run at once.
// Ports    : clk, reset (async, active-low), bus (seq_step_ctrl_if.slave).
module seq_step_ctrl #(
  parameter int PAT_LEN   = 16,
  parameter int LEN_W     = 5,
  parameter int STEP_DIV  = 4,
  parameter int DB_CYCLES = 8,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        reset,
  seq_step_ctrl_if.slave bus
);

  localparam int DIV_W = $clog2(STEP_DIV);
  localparam int DB_W  = $clog2(DB_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_LEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SAMPLE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               busy_q;
  logic [DIV_W-1:0]   div_q;
  logic [LEN_W-1:0]   idx_q;
  logic [LEN_W-1:0]   len_q;
  logic [PAT_LEN-1:0] pattern_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               bit_q;

  // button synchroniser and debouncer
  logic               sync1_q, sync2_q;
  logic               db_level_q, db_prev_q;
  logic [DB_W-1:0]    db_cnt_q;
  logic               db_rise;

  logic               start_ok;
  logic               step_c;
  logic               done_c;
  logic [LEN_W-1:0]   idx_inc;
  logic [LEN_W-1:0]   len_clamp;

  // Shift rather than index so an idx equal to PAT_LEN reads 0 instead of out of range.
  function automatic logic pat_bit(input logic [PAT_LEN-1:0] p, input logic [LEN_W-1:0] i);
    logic [PAT_LEN-1:0] s;
    s = p >> i;
    return s[0];
  endfunction

  assign idx_inc   = idx_q + LEN_W'(1);
  assign len_clamp = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
  assign db_rise   = db_level_q & ~db_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_level_q <= 1'b0;
      db_prev_q  <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      sync1_q   <= bus.btn_next;
      sync2_q   <= sync1_q;
      db_prev_q <= db_level_q;
      // Count consecutive samples that disagree with the accepted level; any
      // agreeing sample (a bounce back) restarts the count.
      if (sync2_q == db_level_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        db_level_q <= sync2_q;
        db_cnt_q   <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    step_c   = 1'b0;
    done_c   = 1'b0;
    start_ok = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && bus.mode && (bus.len != '0)) begin
          start_ok = 1'b1;
          state_d  = S_RUN;
        end else if (!bus.mode && db_rise) begin
          step_c  = 1'b1;
          state_d = S_SAMPLE;
        end
      end
      S_RUN: begin
        // abort wins over a step due in the same cycle
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (div_q == DIV_LAST) begin
          step_c  = 1'b1;
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        // a manual step (busy low) always returns straight to IDLE
        if (bus.abort || !busy_q)  state_d = S_IDLE;
        else if (idx_inc == len_q) state_d = S_DONE;
        else                       state_d = S_RUN;
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q    <= 1'b0;
      div_q     <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      pattern_q <= '0;
      cnt_q     <= '0;
      bit_q     <= 1'b0;
    end else begin
      busy_q <= start_ok | (busy_q & (state_d != S_IDLE));

      if (start_ok) begin
        pattern_q <= bus.pattern;
        len_q     <= len_clamp;
        idx_q     <= '0;
        div_q     <= '0;
        cnt_q     <= '0;
      end else if (busy_q && (state_q == S_RUN || state_q == S_SAMPLE)) begin
        // the divider keeps running through SAMPLE so steps stay evenly spaced
        div_q <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      end

      // the sample still completes in an abort cycle; only the next state changes
      if (state_q == S_SAMPLE) begin
        if (bus.det_in && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
        if (busy_q) idx_q <= idx_inc;
      end

      // bit_out is registered so it is settled at least one cycle before each step
      case (state_q)
        S_IDLE:   bit_q <= start_ok ? bus.pattern[0] : bus.sw_in;
        S_SAMPLE: bit_q <= busy_q ? pat_bit(pattern_q, idx_inc) : bus.sw_in;
        default:  bit_q <= bit_q;
      endcase
    end
  end

  assign bus.step      = step_c;
  assign bus.bit_out   = bit_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_c;
  assign bus.idx       = idx_q;
  assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_step_ctrl.sv
module tb_seq_step_ctrl;
  localparam int PAT_LEN   = 16;
  localparam int LEN_W     = 5;
  localparam int STEP_DIV  = 4;
  localparam int DB_CYCLES = 8;
  localparam int CNT_W     = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seq_step_ctrl_if #(.PAT_LEN(PAT_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) ifc ();
  seq_step_ctrl_if #(.PAT_LEN(PAT_LEN), .LEN_W(LEN_W), .CNT_W(2))     ifc2 ();

  seq_step_ctrl #(.PAT_LEN(PAT_LEN), .LEN_W(LEN_W), .STEP_DIV(STEP_DIV),
                  .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W))
    dut (.clk(clk), .reset(reset), .bus(ifc));

  // narrow-counter copy fed the same stimulus, for saturation
  seq_step_ctrl #(.PAT_LEN(PAT_LEN), .LEN_W(LEN_W), .STEP_DIV(STEP_DIV),
                  .DB_CYCLES(DB_CYCLES), .CNT_W(2))
    dut2 (.clk(clk), .reset(reset), .bus(ifc2));

  assign ifc2.mode     = ifc.mode;
  assign ifc2.btn_next = ifc.btn_next;
  assign ifc2.sw_in    = ifc.sw_in;
  assign ifc2.pattern  = ifc.pattern;
  assign ifc2.len      = ifc.len;
  assign ifc2.start    = ifc.start;
  assign ifc2.abort    = ifc.abort;

  // Moore detector stand-in: output becomes the bit presented on the step edge
  logic det1, det2;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      det1 <= 1'b0;
      det2 <= 1'b0;
    end else begin
      if (ifc.step)  det1 <= ifc.bit_out;
      if (ifc2.step) det2 <= ifc2.bit_out;
    end
  end
  assign ifc.det_in  = det1;
  assign ifc2.det_in = det2;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // step monitor
  int   step_total    = 0;
  int   consec_steps  = 0;
  logic prev_step     = 1'b0;
  logic last_step_bit = 1'b0;
  always @(negedge clk) begin
    if (ifc.step) begin
      step_total    <= step_total + 1;
      last_step_bit <= ifc.bit_out;
    end
    if (ifc.step && prev_step) consec_steps <= consec_steps + 1;
    prev_step <= ifc.step;
  end

  // model state carried across runs
  int m_idx  = 0;
  int m_cnt  = 0;
  int m_cnt2 = 0;

  typedef struct {
    string       name;
    logic        mode;
    logic [15:0] pat;
    logic [4:0]  len;
    int          abort_cyc;
    int          restart_cyc;
    int          exp_steps;
    logic [31:0] exp_bits;
    int          exp_done;   // cycle of done, 0 = never
    int          exp_fall;   // first cycle after start with busy=0
    int          exp_idx;
    int          exp_cnt;
    int          exp_cnt2;
  } vec_t;

  vec_t tv[9];

  // Drives one start request and observes the run; cycle 0 is the cycle start is high.
  task automatic run_auto(input logic m, input logic [15:0] pat, input logic [4:0] ln,
                          input int abort_cyc, input int restart_cyc,
                          output int nsteps, output logic [31:0] bits, output int bad_timing,
                          output int done_cnt, output int done_at, output int fall);
    nsteps = 0; bits = '0; bad_timing = 0; done_cnt = 0; done_at = 0; fall = -1;
    @(posedge clk); #1;
    ifc.mode = m; ifc.pattern = pat; ifc.len = ln;
    for (int cyc = 0; cyc <= STEP_DIV * PAT_LEN + 8; cyc++) begin
      ifc.start = (cyc == 0 || cyc == restart_cyc);
      ifc.abort = (cyc == abort_cyc);
      @(negedge clk);
      if (ifc.step) begin
        if (cyc != STEP_DIV * (nsteps + 1)) bad_timing++;
        if (nsteps < 32) bits[nsteps] = ifc.bit_out;
        nsteps++;
      end
      if (ifc.done) begin
        done_cnt++;
        if (done_at == 0) done_at = cyc;
      end
      if (cyc > 0 && !ifc.busy) begin
        fall = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
  endtask

  task automatic compare_run(input string tag, input int nsteps, input logic [31:0] bits,
                             input int bad_timing, input int done_cnt, input int done_at,
                             input int fall, input vec_t e);
    check({tag, " busy_fall"}, fall, e.exp_fall);
    check({tag, " steps"}, nsteps, e.exp_steps);
    check({tag, " bits"}, bits, e.exp_bits);
    check({tag, " step_spacing"}, bad_timing, 0);
    check({tag, " done_count"}, done_cnt, (e.exp_done != 0) ? 1 : 0);
    check({tag, " done_cycle"}, done_at, e.exp_done);
    check({tag, " idx"}, ifc.idx, e.exp_idx);
    check({tag, " match_cnt"}, ifc.match_cnt, e.exp_cnt);
    check({tag, " match_cnt_sat2"}, ifc2.match_cnt, e.exp_cnt2);
  endtask

  // Button press with bounces on press and release; exp_steps is what the press should yield.
  task automatic manual_press(input string tag, input logic m, input logic sw, input int exp_steps);
    int s0;
    @(posedge clk); #1;
    ifc.mode = m; ifc.sw_in = sw;
    s0 = step_total;
    for (int g = 0; g < 3; g++) begin
      ifc.btn_next = 1'b1; repeat (3) @(posedge clk); #1;
      ifc.btn_next = 1'b0; repeat (2) @(posedge clk); #1;
    end
    ifc.btn_next = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk); #1;
    check({tag, " press_steps"}, step_total - s0, exp_steps);
    if (exp_steps == 1) begin
      check({tag, " step_bit"}, last_step_bit, sw);
      if (sw) begin
        m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
    end
    check({tag, " match_cnt"}, ifc.match_cnt, m_cnt);
    check({tag, " match_cnt_sat2"}, ifc2.match_cnt, m_cnt2);
    check({tag, " idx_held"}, ifc.idx, m_idx);
    @(posedge clk); #1;
    s0 = step_total;
    for (int g = 0; g < 3; g++) begin
      ifc.btn_next = 1'b0; repeat (2) @(posedge clk); #1;
      ifc.btn_next = 1'b1; repeat (3) @(posedge clk); #1;
    end
    ifc.btn_next = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk); #1;
    check({tag, " release_steps"}, step_total - s0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ns, bt, dc, da, fl, L, nst, pc;
    logic [31:0] bits;
    vec_t e;
    logic m;
    logic [15:0] pat;
    logic [4:0] ln;
    int ab, rs;

    ifc.mode = 1'b0; ifc.btn_next = 1'b0; ifc.sw_in = 1'b0; ifc.pattern = '0;
    ifc.len = '0; ifc.start = 1'b0; ifc.abort = 1'b0;

    // reset held while every input toggles: outputs must stay zero
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      ifc.mode = 1'($urandom); ifc.btn_next = 1'($urandom); ifc.sw_in = 1'($urandom);
      ifc.start = 1'($urandom); ifc.abort = 1'($urandom);
      ifc.pattern = 16'($urandom); ifc.len = 5'($urandom);
      @(negedge clk);
      check("reset_outputs", {ifc.step, ifc.busy, ifc.done, ifc.idx, ifc.match_cnt, ifc.bit_out}, 0);
    end
    @(posedge clk); #1;
    ifc.mode = 1'b0; ifc.btn_next = 1'b0; ifc.sw_in = 1'b0; ifc.start = 1'b0; ifc.abort = 1'b0;
    ifc.pattern = '0; ifc.len = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);

    manual_press("manual_sw1", 1'b0, 1'b1, 1);
    manual_press("manual_sw0", 1'b0, 1'b0, 1);
    manual_press("btn_in_auto", 1'b1, 1'b1, 0);

    tv[0] = '{"run_031A",     1'b1, 16'h031A, 5'd11, -1, -1, 11, 32'h031A, 46, 47, 11,  5, 3};
    tv[1] = '{"abort_c13",    1'b1, 16'h031A, 5'd11, 13, -1,  3, 32'h0002,  0, 14,  3,  1, 1};
    tv[2] = '{"restart_c5",   1'b1, 16'h031A, 5'd11, -1,  5, 11, 32'h031A, 46, 47, 11,  5, 3};
    tv[3] = '{"len20_clamp",  1'b1, 16'hFFFF, 5'd20, -1, -1, 16, 32'hFFFF, 66, 67, 16, 16, 3};
    tv[4] = '{"len0_ignored", 1'b1, 16'hABCD, 5'd0,  -1, -1,  0, 32'h0000,  0,  1, 16, 16, 3};
    tv[5] = '{"mode0_start",  1'b0, 16'h00FF, 5'd8,  -1, -1,  0, 32'h0000,  0,  1, 16, 16, 3};
    tv[6] = '{"len1",         1'b1, 16'h0001, 5'd1,  -1, -1,  1, 32'h0001,  6,  7,  1,  1, 1};
    tv[7] = '{"sat_ones6",    1'b1, 16'hFFFF, 5'd6,  -1, -1,  6, 32'h003F, 26, 27,  6,  6, 3};
    tv[8] = '{"msb_only16",   1'b1, 16'h8000, 5'd16, -1, -1, 16, 32'h8000, 66, 67, 16,  1, 1};

    for (int i = 0; i < 9; i++) begin
      run_auto(tv[i].mode, tv[i].pat, tv[i].len, tv[i].abort_cyc, tv[i].restart_cyc,
               ns, bits, bt, dc, da, fl);
      compare_run(tv[i].name, ns, bits, bt, dc, da, fl, tv[i]);
    end
    m_idx = 16; m_cnt = 1; m_cnt2 = 1;

    // random runs against a rule-level model
    for (int r = 0; r < 25; r++) begin
      m   = ($urandom_range(0, 9) != 0);
      pat = 16'($urandom);
      ln  = 5'($urandom_range(0, 20));
      L   = (m && ln != 0) ? ((ln > PAT_LEN) ? PAT_LEN : int'(ln)) : 0;
      ab  = -1;
      rs  = -1;
      if (L != 0) begin
        if ($urandom_range(0, 2) == 0) ab = $urandom_range(1, STEP_DIV * L + 1);
        else if ($urandom_range(0, 3) == 0) rs = $urandom_range(1, STEP_DIV * L + 1);
      end
      e.name = "rand"; e.mode = m; e.pat = pat; e.len = ln;
      e.abort_cyc = ab; e.restart_cyc = rs;
      if (L == 0) begin
        e.exp_steps = 0; e.exp_done = 0; e.exp_fall = 1;
      end else if (ab > 0) begin
        e.exp_steps = (ab - 1) / STEP_DIV; e.exp_done = 0; e.exp_fall = ab + 1;
      end else begin
        e.exp_steps = L; e.exp_done = STEP_DIV * L + 2; e.exp_fall = STEP_DIV * L + 3;
      end
      nst = e.exp_steps;
      e.exp_bits = '0;
      pc = 0;
      for (int k = 0; k < nst; k++) begin
        e.exp_bits[k] = pat[k];
        pc += int'(pat[k]);
      end
      if (L != 0) begin
        m_idx  = nst;
        m_cnt  = (pc > 255) ? 255 : pc;
        m_cnt2 = (pc > 3) ? 3 : pc;
      end
      e.exp_idx = m_idx; e.exp_cnt = m_cnt; e.exp_cnt2 = m_cnt2;
      run_auto(m, pat, ln, ab, rs, ns, bits, bt, dc, da, fl);
      compare_run($sformatf("rand%0d", r), ns, bits, bt, dc, da, fl, e);
    end

    // reset in the middle of a run clears everything at once
    @(posedge clk); #1;
    ifc.mode = 1'b1; ifc.pattern = 16'h031A; ifc.len = 5'd11; ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    check("midrun_busy", ifc.busy, 1);
    check("midrun_idx", ifc.idx, 2);
    reset = 1'b0;
    #1;
    check("midrun_reset", {ifc.step, ifc.busy, ifc.done, ifc.idx, ifc.match_cnt, ifc.bit_out}, 0);
    check("midrun_reset_sat2", ifc2.match_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("post_reset_idle", {ifc.busy, ifc.step, ifc.done}, 0);
    check("no_back_to_back_steps", consec_steps, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_step_ctrl.md
Name: seq_step_ctrl

Overview:
Step sequencer for the sequence-detector FSM. It produces a single-cycle `step` strobe and a data bit (`bit_out`) that drive the detector's step and data inputs.
- Manual mode: strobes come from a debounced push button and the bit comes from a switch.
- Auto mode: strobes are timed, and the bits replay a loaded pattern LSB-first.
- In both modes, the detector's output is sampled after every step and detections are counted.

Parameters:
PAT_LEN, 16, pattern register width (maximum replay length)
LEN_W, 5, width of len/idx (must hold PAT_LEN)
STEP_DIV, 4, clock cycles between auto steps (>=4)
DB_CYCLES, 8, consecutive stable samples required to accept a button level
CNT_W, 8, match counter width (saturating)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
mode  in  1  0 = manual, 1 = auto; sampled only in IDLE
btn_next  in  1  raw, asynchronous, bouncy push button
sw_in  in  1  manual data bit
pattern  in  PAT_LEN  replay pattern, bit 0 played first
len  in  LEN_W  number of bits to replay
start  in  1  single-cycle auto-run request
abort  in  1  stop an auto run
det_in  in  1  detector output (Moore, updates on the step edge)
step  out  1  single-cycle step strobe to the detector
bit_out  out  1  data bit to the detector, stable from 1 cycle before through the step cycle
busy  out  1  auto run in progress
done  out  1  single-cycle run-complete pulse
idx  out  LEN_W  index of the next pattern bit
match_cnt  out  CNT_W  count of det_in==1 samples, saturating

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE; all outputs 0; debounced level 0; divider and internal registers 0.
- btn_next synchronisation: two-flop synchroniser, then a stability counter. The debounced level takes the synchronised value after DB_CYCLES consecutive equal samples.
- Manual step: rising edge of the debounced level while IDLE and mode=0 gives step=1 for exactly 1 cycle. bit_out = sw_in, registered every cycle while IDLE.
- Button edges are ignored in RUN, in auto mode, or in any state other than IDLE.
- FSM states: IDLE, RUN, SAMPLE, DONE.
- IDLE -> RUN when start=1, mode=1 and len!=0. On that edge:
  - latch pattern into pattern_q;
  - latch len_q = min(len, PAT_LEN);
  - idx=0, divider=0, match_cnt=0, busy=1.
- start with len=0 or mode=0 is ignored. start while busy is ignored.
- RUN behaviour:
  - divider counts 0..STEP_DIV-1;
  - bit_out = pattern_q[idx];
  - when divider=STEP_DIV-1: step=1 for that cycle, divider wraps to 0, go to SAMPLE.
- Timing: the start edge is cycle 0. Steps occur in cycles STEP_DIV, 2*STEP_DIV, and so on.
- SAMPLE (1 cycle, auto and manual alike):
  - if det_in=1, match_cnt++ (saturates at all-ones);
  - idx++ (auto only);
  - if the new idx = len_q go to DONE, else return to RUN (divider keeps counting).
- Manual steps also enter SAMPLE, then return to IDLE. idx does not change in manual mode.
- DONE (1 cycle): done=1, busy still 1; next state IDLE with busy=0.
- In manual mode match_cnt is cleared only by reset or by an auto start.
- abort=1 in RUN or SAMPLE: next state IDLE, busy=0, no further step, no done. match_cnt and idx hold. abort has priority over a step in the same cycle.
- mode changes during a run are ignored until IDLE.
- Reset mid-run: immediately forces all reset values.
- step is never asserted in two consecutive cycles.

Test Plan:
1. Reset asserted with inputs toggling -> step, busy, done, idx, match_cnt = 0; bit_out=0.
2. Manual: btn_next bounces 3 times (each glitch < DB_CYCLES), then holds 1, with sw_in=1 -> exactly one step pulse; bit_out=1 during it; no step on release.
3. Auto run: pattern=16'h031A, len=11, STEP_DIV=4, det_in = bit_out registered on step.
   - Required: steps in cycles 4..44 (every 4), bit sequence 0,1,0,1,1,0,0,0,1,1,0.
   - done=1 in cycle 46; match_cnt=5; idx=11.
4. abort asserted in cycle 13 of the run above -> no further step, busy=0 in cycle 14, done never asserted, idx=3.
5. CNT_W=2, pattern all ones, len=6, det_in=1 -> match_cnt saturates at 3.
6. Guard cases:
   - start with len=0 -> stays IDLE, busy=0.
   - second start in cycle 5 of a run -> ignored.
   - len=20 -> clamped to 16 steps.
